// File: rtl/gpio_input_filter_pkg.sv
// Shared constants, register map and types for the GPIO input filter.
// Imported by the bus interface, the per-bit debouncer and the top level.
package gpio_filt_pkg;

   localparam int NUM_BITS    = 72;
   localparam int REG_WIDTH   = 24;
   localparam int CNT_WIDTH   = 8;
   localparam int PRESC_WIDTH = 16;
   localparam int BUS_WIDTH   = 32;
   localparam int ADDR_WIDTH  = 4;

   function automatic int calc_num_words(input int nbits, input int width);
      return (nbits + width - 1) / width;
   endfunction

   localparam int NUM_WORDS = calc_num_words(NUM_BITS, REG_WIDTH);
   localparam int PAD_BITS  = NUM_WORDS * REG_WIDTH;

   typedef logic [ADDR_WIDTH-1:0]  addr_t;
   typedef logic [CNT_WIDTH-1:0]   cnt_t;
   typedef logic [PRESC_WIDTH-1:0] presc_t;

   localparam addr_t FILT_W0    = 4'd0;
   localparam addr_t EVENT_W0   = 4'd3;
   localparam addr_t RISE_W0    = 4'd6;
   localparam addr_t FALL_W0    = 4'd9;
   localparam addr_t PERIOD_IDX = 4'd12;
   localparam addr_t PRESC_IDX  = 4'd13;
   localparam addr_t CTRL_IDX   = 4'd14;

endpackage

// File: rtl/gpio_input_filter_if.sv
// Local register bus of the GPIO input filter: single-cycle read/write strobes,
// registered read data with a one-cycle valid pulse.
interface gpio_input_filter_if;
   import gpio_filt_pkg::*;

   addr_t                reg_addr;
   logic                 reg_wr;
   logic [BUS_WIDTH-1:0] reg_wdata;
   logic                 reg_rd;
   logic [BUS_WIDTH-1:0] reg_rdata;
   logic                 rd_valid;

   modport master (
      output reg_addr, reg_wr, reg_wdata, reg_rd,
      input  reg_rdata, rd_valid
   );

   modport slave (
      input  reg_addr, reg_wr, reg_wdata, reg_rd,
      output reg_rdata, rd_valid
   );

endinterface

// File: rtl/gpio_input_filter_debounce_bit.sv
// One GPIO bit: two-flop synchroniser, tick-driven debounce counter, filtered
// state and its one-cycle delayed copy for edge detection.
module gpio_debounce_bit
   import gpio_filt_pkg::*;
(
   input  logic reg_clk,
   input  logic reset_in,
   input  logic i_gpio,
   input  logic i_tick,
   input  cnt_t i_period,
   output logic o_filt,
   output logic o_filt_d
);

   logic r_sync1;
   logic r_sync2;
   logic r_filt;
   logic r_filt_d;
   cnt_t r_cnt;
   cnt_t w_cnt_inc;

   assign w_cnt_inc = r_cnt + cnt_t'(1);

   // Synchronise, then accept the new level once it has differed for PERIOD ticks
   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_filt   <= 1'b0;
         r_filt_d <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1  <= i_gpio;
         r_sync2  <= r_sync1;
         r_filt_d <= r_filt;
         if (i_period == '0) begin
            r_filt <= r_sync2;
            r_cnt  <= '0;
         end else if (r_sync2 == r_filt) begin
            r_cnt <= '0;
         end else if (i_tick) begin
            // Equality is tested before the increment can wrap, so a count left
            // above a newly lowered PERIOD resolves after wrapping round.
            if (w_cnt_inc == i_period) begin
               r_filt <= r_sync2;
               r_cnt  <= '0;
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end
      end
   end

   assign o_filt   = r_filt;
   assign o_filt_d = r_filt_d;

endmodule

// File: rtl/gpio_input_filter.sv
// GPIO input conditioning: per-bit debounce, rise/fall event latch with W1C,
// shared tick prescaler, 24-bit-per-word register file and level interrupt.
module gpio_input_filter
   import gpio_filt_pkg::*;
(
   input  logic                reg_clk,
   input  logic                reset_in,
   input  logic [NUM_BITS-1:0] i_gpio_in,
   gpio_input_filter_if.slave  reg_bus,
   output logic [NUM_BITS-1:0] o_filt_out,
   output logic                o_irq
);

   logic [NUM_BITS-1:0]  w_filt;
   logic [NUM_BITS-1:0]  w_filt_d;
   logic [NUM_BITS-1:0]  w_set;
   logic [NUM_BITS-1:0]  w_wr_bits;
   logic [NUM_BITS-1:0]  w_ev_mask;
   logic [NUM_BITS-1:0]  w_rise_mask;
   logic [NUM_BITS-1:0]  w_fall_mask;
   logic [NUM_BITS-1:0]  r_event;
   logic [NUM_BITS-1:0]  r_rise_en;
   logic [NUM_BITS-1:0]  r_fall_en;
   logic [PAD_BITS-1:0]  w_filt_pad;
   logic [PAD_BITS-1:0]  w_event_pad;
   logic [PAD_BITS-1:0]  w_rise_pad;
   logic [PAD_BITS-1:0]  w_fall_pad;
   logic [15:0]          w_wr_sel;
   logic [BUS_WIDTH-1:0] w_rd_data;
   logic [BUS_WIDTH-1:0] r_rdata;
   logic                 r_rd_valid;
   cnt_t                 r_period;
   presc_t               r_presc;
   presc_t               r_presc_cnt;
   logic                 r_irq_en;
   logic                 r_irq;
   logic                 w_tick;
   logic                 w_unused_wdata;

   function automatic logic [REG_WIDTH-1:0] pick_word(input logic [PAD_BITS-1:0] vec,
                                                       input addr_t idx);
      return vec[int'(idx) * REG_WIDTH +: REG_WIDTH];
   endfunction

   assign w_tick         = (r_presc_cnt == '0);
   assign w_wr_sel       = reg_bus.reg_wr ? (16'd1 << reg_bus.reg_addr) : 16'd0;
   assign w_unused_wdata = ^reg_bus.reg_wdata[BUS_WIDTH-1:REG_WIDTH];

   for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_bit
      gpio_debounce_bit u_bit (
         .reg_clk  (reg_clk),
         .reset_in (reset_in),
         .i_gpio   (i_gpio_in[gi]),
         .i_tick   (w_tick),
         .i_period (r_period),
         .o_filt   (w_filt[gi]),
         .o_filt_d (w_filt_d[gi])
      );
      assign w_wr_bits[gi]   = reg_bus.reg_wdata[gi % REG_WIDTH];
      assign w_ev_mask[gi]   = w_wr_sel[int'(EVENT_W0) + gi / REG_WIDTH];
      assign w_rise_mask[gi] = w_wr_sel[int'(RISE_W0) + gi / REG_WIDTH];
      assign w_fall_mask[gi] = w_wr_sel[int'(FALL_W0) + gi / REG_WIDTH];
   end

   assign w_set = (w_filt & ~w_filt_d & r_rise_en) | (~w_filt & w_filt_d & r_fall_en);

   // Prescaler: down-counter reloaded from PRESC, restarted by a PRESC write
   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         r_presc_cnt <= '0;
      end else if (w_wr_sel[PRESC_IDX]) begin
         r_presc_cnt <= reg_bus.reg_wdata[PRESC_WIDTH-1:0];
      end else if (w_tick) begin
         r_presc_cnt <= r_presc;
      end else begin
         r_presc_cnt <= r_presc_cnt - presc_t'(1);
      end
   end

   // Register file, event latch (a new edge beats a same-cycle clear) and irq
   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         r_event   <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
         r_period  <= '0;
         r_presc   <= '0;
         r_irq_en  <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_event   <= (r_event & ~(w_ev_mask & w_wr_bits)) | w_set;
         r_rise_en <= (r_rise_en & ~w_rise_mask) | (w_wr_bits & w_rise_mask);
         r_fall_en <= (r_fall_en & ~w_fall_mask) | (w_wr_bits & w_fall_mask);
         if (w_wr_sel[PERIOD_IDX]) r_period <= reg_bus.reg_wdata[CNT_WIDTH-1:0];
         if (w_wr_sel[PRESC_IDX])  r_presc  <= reg_bus.reg_wdata[PRESC_WIDTH-1:0];
         if (w_wr_sel[CTRL_IDX])   r_irq_en <= reg_bus.reg_wdata[0];
         r_irq <= r_irq_en & (|r_event);
      end
   end

   // Zero-extend the bit vectors to whole register words
   always_comb begin
      w_filt_pad                 = '0;
      w_event_pad                = '0;
      w_rise_pad                 = '0;
      w_fall_pad                 = '0;
      w_filt_pad[NUM_BITS-1:0]   = w_filt;
      w_event_pad[NUM_BITS-1:0]  = r_event;
      w_rise_pad[NUM_BITS-1:0]   = r_rise_en;
      w_fall_pad[NUM_BITS-1:0]   = r_fall_en;
   end

   // Read mux; index 15 falls through to zero
   always_comb begin
      w_rd_data = '0;
      case (reg_bus.reg_addr)
         FILT_W0, FILT_W0 + 4'd1, FILT_W0 + 4'd2:
            w_rd_data[REG_WIDTH-1:0] = pick_word(w_filt_pad, reg_bus.reg_addr - FILT_W0);
         EVENT_W0, EVENT_W0 + 4'd1, EVENT_W0 + 4'd2:
            w_rd_data[REG_WIDTH-1:0] = pick_word(w_event_pad, reg_bus.reg_addr - EVENT_W0);
         RISE_W0, RISE_W0 + 4'd1, RISE_W0 + 4'd2:
            w_rd_data[REG_WIDTH-1:0] = pick_word(w_rise_pad, reg_bus.reg_addr - RISE_W0);
         FALL_W0, FALL_W0 + 4'd1, FALL_W0 + 4'd2:
            w_rd_data[REG_WIDTH-1:0] = pick_word(w_fall_pad, reg_bus.reg_addr - FALL_W0);
         PERIOD_IDX: w_rd_data[CNT_WIDTH-1:0]   = r_period;
         PRESC_IDX:  w_rd_data[PRESC_WIDTH-1:0] = r_presc;
         CTRL_IDX:   w_rd_data[0]               = r_irq_en;
         default:    w_rd_data                  = '0;
      endcase
   end

   // Registered read port: data holds until the next read strobe
   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         r_rdata    <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= reg_bus.reg_rd;
         if (reg_bus.reg_rd) r_rdata <= w_rd_data;
      end
   end

   assign reg_bus.reg_rdata = r_rdata;
   assign reg_bus.rd_valid  = r_rd_valid;
   assign o_filt_out        = w_filt;
   assign o_irq             = r_irq;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Self-checking bench for gpio_input_filter: directed latency/debounce/W1C/reset
// steps plus a randomized PERIOD=0 phase checked against a history-based model.
module tb_gpio_input_filter;

   logic        reg_clk = 1'b0;
   logic        reset_in = 1'b1;
   logic [71:0] gpio_in = '0;
   logic [71:0] filt_out;
   logic        irq;

   gpio_input_filter_if bus();

   gpio_input_filter dut (
      .reg_clk    (reg_clk),
      .reset_in   (reset_in),
      .i_gpio_in  (gpio_in),
      .reg_bus    (bus),
      .o_filt_out (filt_out),
      .o_irq      (irq)
   );

   always #5 reg_clk = ~reg_clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: sampled-input history gives filt (fixed 3-cycle path when
   // PERIOD=0), plus the architectural registers as software sees them.
   logic [71:0] m_g[$];
   logic [71:0] m_ev, m_re, m_fe;
   logic [7:0]  m_per;
   logic [15:0] m_presc;
   logic        m_irqen, m_irq, m_rdv;
   logic [31:0] m_rdata;
   bit          m_chk;

   task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(int a);
      logic [71:0] f;
      logic [31:0] r;
      f = m_g[m_g.size()-3];
      r = '0;
      case (a)
         0, 1, 2:  r[23:0] = f[a*24 +: 24];
         3, 4, 5:  r[23:0] = m_ev[(a-3)*24 +: 24];
         6, 7, 8:  r[23:0] = m_re[(a-6)*24 +: 24];
         9, 10, 11: r[23:0] = m_fe[(a-9)*24 +: 24];
         12: r[7:0]  = m_per;
         13: r[15:0] = m_presc;
         14: r[0]    = m_irqen;
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic m_write(int a, logic [31:0] d);
      case (a)
         6, 7, 8:  m_re[(a-6)*24 +: 24] = d[23:0];
         9, 10, 11: m_fe[(a-9)*24 +: 24] = d[23:0];
         12: m_per   = d[7:0];
         13: m_presc = d[15:0];
         14: m_irqen = d[0];
         default: ;
      endcase
   endtask

   task automatic model_reset();
      m_g = {};
      repeat (5) m_g.push_back(72'd0);
      m_ev = '0; m_re = '0; m_fe = '0; m_per = '0; m_presc = '0;
      m_irqen = 1'b0; m_irq = 1'b0; m_rdv = 1'b0; m_rdata = '0;
   endtask

   // One clock: advance the model with the inputs being presented, then compare.
   task automatic cyc();
      logic [71:0] f_o, fd_o, set_v, clr_v;
      int a;
      a     = int'(bus.reg_addr);
      f_o   = m_g[m_g.size()-3];
      fd_o  = m_g[m_g.size()-4];
      set_v = (f_o & ~fd_o & m_re) | (~f_o & fd_o & m_fe);
      clr_v = '0;
      if (bus.reg_wr && a >= 3 && a <= 5) clr_v[(a-3)*24 +: 24] = bus.reg_wdata[23:0];
      if (bus.reg_rd) m_rdata = m_read(a);
      m_rdv = bus.reg_rd;
      m_irq = m_irqen & (|m_ev);
      m_ev  = (m_ev & ~clr_v) | set_v;
      if (bus.reg_wr) m_write(a, bus.reg_wdata);
      m_g.push_back(gpio_in);
      void'(m_g.pop_front());
      @(posedge reg_clk);
      #1;
      if (m_chk) begin
         chk("model_filt", filt_out, m_g[m_g.size()-3]);
         chk("model_irq", 72'(irq), 72'(m_irq));
         chk("model_rd_valid", 72'(bus.rd_valid), 72'(m_rdv));
         if (m_rdv) chk("model_rdata", 72'(bus.reg_rdata), 72'(m_rdata));
      end
   endtask

   task automatic wr(int a, logic [31:0] d);
      bus.reg_addr = 4'(a); bus.reg_wdata = d; bus.reg_wr = 1'b1;
      cyc();
      bus.reg_wr = 1'b0;
   endtask

   task automatic rd(int a, output logic [31:0] d);
      bus.reg_addr = 4'(a); bus.reg_rd = 1'b1;
      cyc();
      chk($sformatf("rd_valid_w%0d", a), 72'(bus.rd_valid), 72'd1);
      d = bus.reg_rdata;
      bus.reg_rd = 1'b0;
      cyc();
      chk($sformatf("rd_valid_pulse_w%0d", a), 72'(bus.rd_valid), 72'd0);
   endtask

   task automatic do_reset();
      reset_in = 1'b1; gpio_in = '0;
      bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
      model_reset();
      @(posedge reg_clk); #1;
      @(posedge reg_clk); #1;
      reset_in = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        seen;
      int          n;

      // Reset state and full register sweep
      m_chk = 1'b1;
      do_reset();
      chk("reset_filt", filt_out, 72'd0);
      chk("reset_irq", 72'(irq), 72'd0);
      chk("reset_rd_valid", 72'(bus.rd_valid), 72'd0);
      chk("reset_rdata", 72'(bus.reg_rdata), 72'd0);
      for (int k = 0; k < 16; k++) begin
         rd(k, d);
         chk($sformatf("reset_word%0d", k), 72'(d), 72'd0);
      end

      // PERIOD=0 latency: filt +3, event +4, irq +5, then W1C
      wr(6, 32'h000001);
      wr(14, 32'h1);
      gpio_in[0] = 1'b1;
      cyc(); cyc();
      chk("lat_filt_c2", 72'(filt_out[0]), 72'd0);
      cyc();
      chk("lat_filt_c3", 72'(filt_out[0]), 72'd1);
      cyc();
      chk("lat_irq_c4", 72'(irq), 72'd0);
      cyc();
      chk("lat_irq_c5", 72'(irq), 72'd1);
      rd(3, d);
      chk("lat_event_w3", 72'(d), 72'h000001);
      wr(3, 32'h000001);
      chk("w1c_irq_c1", 72'(irq), 72'd1);
      cyc();
      chk("w1c_irq_c2", 72'(irq), 72'd0);

      // Randomized PERIOD=0 traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ (72'd1 << $urandom_range(0, 71));
         if ($urandom_range(0, 15) == 0) gpio_in = 72'({$urandom, $urandom, $urandom});
         bus.reg_wr    = ($urandom_range(0, 5) == 0);
         bus.reg_rd    = ($urandom_range(0, 3) == 0);
         bus.reg_wdata = $urandom;
         bus.reg_addr  = bus.reg_wr ? 4'($urandom_range(3, 11)) : 4'($urandom_range(0, 15));
         cyc();
      end
      bus.reg_wr = 1'b0; bus.reg_rd = 1'b0;

      // Debounce: PERIOD=4 ticks, tick every 10 cycles
      m_chk = 1'b0;
      do_reset();
      wr(12, 32'd4);
      wr(13, 32'd9);
      gpio_in[30] = 1'b1;
      seen = 1'b0;
      repeat (35) begin cyc(); seen = seen | filt_out[30]; end
      gpio_in[30] = 1'b0;
      repeat (10) begin cyc(); seen = seen | filt_out[30]; end
      chk("glitch_no_filt", 72'(seen), 72'd0);
      gpio_in[30] = 1'b1;
      n = 0;
      while (filt_out[30] == 1'b0 && n < 80) begin cyc(); n++; end
      chk($sformatf("debounce_window_n%0d", n), 72'(n >= 30 && n <= 50), 72'd1);
      chk("debounce_filt_vec", filt_out, 72'd1 << 30);
      rd(1, d);
      chk("debounce_w1", 72'(d), 72'h000040);
      rd(4, d);
      chk("debounce_no_event", 72'(d), 72'd0);

      // Fall-only enable on bit 71, with ignored upper write bits
      wr(12, 32'd0);
      wr(14, 32'h1);
      wr(11, 32'hFF800000);
      rd(11, d);
      chk("fall_en_w11", 72'(d), 72'h800000);
      gpio_in[71] = 1'b1;
      repeat (6) cyc();
      rd(5, d);
      chk("rise_no_event_w5", 72'(d), 72'd0);
      chk("rise_no_irq", 72'(irq), 72'd0);
      gpio_in[71] = 1'b0;
      repeat (6) cyc();
      rd(5, d);
      chk("fall_event_w5", 72'(d), 72'h800000);
      rd(4, d);
      chk("fall_event_w4", 72'(d), 72'd0);
      chk("fall_irq", 72'(irq), 72'd1);

      // Event set and W1C in the same cycle: set wins
      wr(5, 32'h800000);
      cyc();
      chk("clear_irq", 72'(irq), 72'd0);
      gpio_in[71] = 1'b1;
      repeat (6) cyc();
      gpio_in[71] = 1'b0;
      cyc(); cyc(); cyc();
      wr(5, 32'h800000);
      cyc();
      chk("setwins_irq", 72'(irq), 72'd1);
      rd(5, d);
      chk("setwins_w5", 72'(d), 72'h800000);

      // Asynchronous reset during a PERIOD=200 count
      wr(12, 32'd200);
      gpio_in[5] = 1'b1;
      repeat (50) cyc();
      #2;
      reset_in = 1'b1;
      #1;
      chk("areset_filt", filt_out, 72'd0);
      chk("areset_irq", 72'(irq), 72'd0);
      chk("areset_rd_valid", 72'(bus.rd_valid), 72'd0);
      chk("areset_rdata", 72'(bus.reg_rdata), 72'd0);
      gpio_in = '0;
      model_reset();
      @(posedge reg_clk); #1;
      reset_in = 1'b0;
      wr(12, 32'd200);
      gpio_in[5] = 1'b1;
      repeat (201) cyc();
      chk("p200_before", 72'(filt_out[5]), 72'd0);
      cyc();
      chk("p200_after", 72'(filt_out[5]), 72'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
